// File: rtl/throw_charge_if.sv
// Bundle between the launch-side throw controller and its player/trajectory
// peers.
// enable rises together with a valid throw_force and stays high for the whole
// flight; turn_over is a one-cycle pulse; hit_in is a one-cycle pulse sampled
// only during flight.
interface throw_charge_if;
  logic       btn;
  logic       turn_en;
  logic       hit_in;
  logic [9:0] throw_force;
  logic       enable;
  logic       charging;
  logic       turn_over;
  logic       last_hit;
  logic [1:0] state_dbg;

  modport master (
    output btn, turn_en, hit_in,
    input  throw_force, enable, charging, turn_over, last_hit, state_dbg
  );

  modport slave (
    input  btn, turn_en, hit_in,
    output throw_force, enable, charging, turn_over, last_hit, state_dbg
  );
endinterface

// File: rtl/throw_charge_ctl.sv
// Charge-and-launch controller: a button hold becomes throw_force, and enable is held for the flight.
// Optional THROW_CHARGE_PINGPONG_EN makes the charge oscillate between FORCE_MIN and FORCE_MAX.
module throw_charge_ctl #(
  parameter int TICK_DIV     = 1_300_000,
  parameter int FORCE_STEP   = 8,
  parameter int FORCE_MIN    = 20,
  parameter int FORCE_MAX    = 1000,
  parameter int FLIGHT_TICKS = 250
) (
  input  logic           clk,
  input  logic           rst,
  throw_charge_if.slave  bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLIGHT_TICKS > 1) ? $clog2(FLIGHT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLIGHT_LAST = FW'(FLIGHT_TICKS - 1);
  localparam logic [10:0]   STEP        = 11'(FORCE_STEP);
  localparam logic [10:0]   FMIN        = 11'(FORCE_MIN);
  localparam logic [10:0]   FMAX        = 11'(FORCE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLIGHT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            sync1, btn_s, btn_q;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [9:0]      force_q, force_nxt;
  logic [10:0]     force_up;
  logic [FW-1:0]   flight_cnt, flight_cnt_nxt;
  logic            last_hit_q, last_hit_nxt;
  logic            enable_q, charging_q, turn_over_q;
`ifdef THROW_CHARGE_PINGPONG_EN
  logic            dir_dn, dir_dn_nxt;
  logic [10:0]     force_dn;
  assign force_dn = {1'b0, force_q} - STEP;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      btn_q <= 1'b0;
    end else begin
      sync1 <= bus.btn;
      btn_s <= sync1;
      btn_q <= btn_s;
    end
  end

  // Free-running timebase, deliberately independent of the FSM.
  assign tick = (tick_cnt == TICK_LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  assign force_up = {1'b0, force_q} + STEP;

  always_comb begin
    state_nxt      = state;
    force_nxt      = force_q;
    flight_cnt_nxt = flight_cnt;
    last_hit_nxt   = last_hit_q;
`ifdef THROW_CHARGE_PINGPONG_EN
    dir_dn_nxt     = dir_dn;
`endif
    case (state)
      IDLE: begin
        if (bus.turn_en && btn_s && !btn_q) begin
          state_nxt = CHARGE;
          force_nxt = '0;
`ifdef THROW_CHARGE_PINGPONG_EN
          dir_dn_nxt = 1'b0;
`endif
        end
      end
      CHARGE: begin
        if (!bus.turn_en) begin
          state_nxt = IDLE;
        end else if (!btn_s) begin
          state_nxt      = FLIGHT;
          flight_cnt_nxt = '0;
          if ({1'b0, force_q} < FMIN) force_nxt = FMIN[9:0];
        end else if (tick) begin
`ifdef THROW_CHARGE_PINGPONG_EN
          if (!dir_dn) begin
            if (force_up >= FMAX) begin
              force_nxt  = FMAX[9:0];
              dir_dn_nxt = 1'b1;
            end else begin
              force_nxt  = force_up[9:0];
            end
          end else if ({1'b0, force_q} <= FMIN + STEP) begin
            force_nxt  = FMIN[9:0];
            dir_dn_nxt = 1'b0;
          end else begin
            force_nxt  = force_dn[9:0];
          end
`else
          force_nxt = (force_up >= FMAX) ? FMAX[9:0] : force_up[9:0];
`endif
        end
      end
      FLIGHT: begin
        if (tick) flight_cnt_nxt = flight_cnt + FW'(1);
        // A hit wins over a same-cycle timeout.
        if (bus.hit_in) begin
          last_hit_nxt = 1'b1;
          state_nxt    = DONE;
        end else if (tick && flight_cnt == FLIGHT_LAST) begin
          last_hit_nxt = 1'b0;
          state_nxt    = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      force_q     <= '0;
      flight_cnt  <= '0;
      last_hit_q  <= 1'b0;
      enable_q    <= 1'b0;
      charging_q  <= 1'b0;
      turn_over_q <= 1'b0;
`ifdef THROW_CHARGE_PINGPONG_EN
      dir_dn      <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      force_q     <= force_nxt;
      flight_cnt  <= flight_cnt_nxt;
      last_hit_q  <= last_hit_nxt;
      enable_q    <= (state_nxt == FLIGHT);
      charging_q  <= (state_nxt == CHARGE);
      turn_over_q <= (state_nxt == DONE);
`ifdef THROW_CHARGE_PINGPONG_EN
      dir_dn      <= dir_dn_nxt;
`endif
    end
  end

  assign bus.throw_force = force_q;
  assign bus.enable      = enable_q;
  assign bus.charging    = charging_q;
  assign bus.turn_over   = turn_over_q;
  assign bus.last_hit    = last_hit_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_throw_charge_ctl.sv
// Directed bench for throw_charge_ctl: a table of throws plus turn_en,
// IDLE-hit and mid-flight reset sequences.
module tb_throw_charge_ctl;
  localparam int TICK_DIV     = 4;
  localparam int FORCE_STEP   = 100;
  localparam int FORCE_MIN    = 20;
  localparam int FORCE_MAX    = 1000;
  localparam int FLIGHT_TICKS = 5;
`ifdef THROW_CHARGE_PINGPONG_EN
  localparam int HOLD15_FORCE = 500;
`else
  localparam int HOLD15_FORCE = 1000;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   seen;

  typedef struct {
    int hold;
    int hit_after;
    int exp_force;
    int exp_dur;
    int exp_last_hit;
  } vec_t;
  vec_t vecs[7];

  throw_charge_if bus ();

  throw_charge_ctl #(
    .TICK_DIV    (TICK_DIV),
    .FORCE_STEP  (FORCE_STEP),
    .FORCE_MIN   (FORCE_MIN),
    .FORCE_MAX   (FORCE_MAX),
    .FLIGHT_TICKS(FLIGHT_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset-aligned edge count; equals the tick phase of the DUT
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Press at tick phase 0, hold, release, then follow the flight to IDLE.
  task automatic run_throw(input vec_t v);
    int rl;
    int dur;
    int f0;
    int frozen_ok;
    while (cyc % TICK_DIV != 0) @(negedge clk);
    bus.btn = 1'b1;
    for (int i = 1; i <= v.hold; i++) begin
      @(negedge clk);
      if (i == 2) chk("press_lat_lo", bus.charging, 0);
      if (i == 3) chk("press_lat_hi", bus.charging, 1);
    end
    bus.btn = 1'b0;
    rl = 0;
    while (!bus.enable && rl < 10) begin
      @(negedge clk);
      rl++;
    end
    chk("release_lat", rl, 3);
    chk("charging_off_in_flight", bus.charging, 0);
    chk("force_at_launch", bus.throw_force, v.exp_force);
    f0 = bus.throw_force;
    frozen_ok = 1;
    dur = 0;
    while (bus.enable && dur < 200) begin
      dur++;
      if (bus.throw_force != f0 || bus.turn_over) frozen_ok = 0;
      if (dur == v.hit_after) bus.hit_in = 1'b1;
      @(negedge clk);
      bus.hit_in = 1'b0;
    end
    chk("force_frozen", frozen_ok, 1);
    chk("flight_len", dur, v.exp_dur);
    chk("turn_over_pulse", bus.turn_over, 1);
    chk("last_hit", bus.last_hit, v.exp_last_hit);
    @(negedge clk);
    chk("turn_over_clear", bus.turn_over, 0);
    chk("enable_low_idle", bus.enable, 0);
    chk("state_idle", bus.state_dbg, 0);
    chk("force_held_idle", bus.throw_force, v.exp_force);
  endtask

  initial begin
    // hold, hit_after (0 = none), force, enable-high cycles, last_hit
    vecs[0] = '{12, 0,  300,          17, 0};
    vecs[1] = '{1,  0,  20,           20, 0};
    vecs[2] = '{60, 0,  HOLD15_FORCE, 17, 0};
    vecs[3] = '{12, 8,  300,          8,  1};
    vecs[4] = '{6,  0,  200,          19, 0};
    vecs[5] = '{12, 1,  300,          1,  1};
    vecs[6] = '{12, 17, 300,          17, 1};

    bus.btn = 1'b0;
    bus.turn_en = 1'b1;
    bus.hit_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_force", bus.throw_force, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_charging", bus.charging, 0);
    chk("rst_turn_over", bus.turn_over, 0);
    chk("rst_last_hit", bus.last_hit, 0);
    chk("rst_state", bus.state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_throw(vecs[i]);
      repeat (3) @(negedge clk);
    end

    // hit_in while idle must be ignored
    bus.hit_in = 1'b1;
    @(negedge clk);
    bus.hit_in = 1'b0;
    @(negedge clk);
    chk("idle_hit_enable", bus.enable, 0);
    chk("idle_hit_turn_over", bus.turn_over, 0);
    chk("idle_hit_last_hit", bus.last_hit, 1);
    chk("idle_hit_state", bus.state_dbg, 0);

    // button already held when the turn starts
    bus.turn_en = 1'b0;
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.turn_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_btn_no_charge", bus.charging, 0);
    chk("held_btn_state", bus.state_dbg, 0);
    bus.btn = 1'b0;
    repeat (4) @(negedge clk);

    // abort a charge by dropping turn_en
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_charge_started", bus.charging, 1);
    bus.turn_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.enable || bus.turn_over) seen = 1;
    end
    chk("abort_charging_off", bus.charging, 0);
    chk("abort_no_enable_turn_over", seen, 0);
    chk("abort_state", bus.state_dbg, 0);
    bus.btn = 1'b0;
    repeat (4) @(negedge clk);
    bus.turn_en = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of a flight
    while (cyc % TICK_DIV != 0) @(negedge clk);
    bus.btn = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn = 1'b0;
    lat = 0;
    while (!bus.enable && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("pre_rst_enable", bus.enable, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable", bus.enable, 0);
    chk("async_rst_force", bus.throw_force, 0);
    chk("async_rst_last_hit", bus.last_hit, 0);
    chk("async_rst_turn_over", bus.turn_over, 0);
    chk("async_rst_charging", bus.charging, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.enable || bus.turn_over || bus.charging) seen = 1;
    end
    chk("post_rst_quiet", seen, 0);
    run_throw(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
